// File: rtl/cl_sde_pkg.sv
// cl_sde_pkg
//   Shared constants and types for the SDE classifier result sink:
//   score geometry, result FIFO sizing, register byte offsets, the
//   argmax result record and a saturating counter helper.
package cl_sde_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 16;
  localparam int CLS_W       = 4;
  localparam int FIFO_DEPTH  = 16;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  localparam logic [11:0] REG_CTRL        = 12'h000;
  localparam logic [11:0] REG_STATUS      = 12'h004;
  localparam logic [11:0] REG_RESULT      = 12'h008;
  localparam logic [11:0] REG_NUM_RESULTS = 12'h00C;
  localparam logic [11:0] REG_KEEP_ERR    = 12'h010;
  localparam logic [11:0] REG_LAST_ERR    = 12'h014;

  // Bytes that must be qualified by keep on every beat (20 bytes = 10 scores).
  localparam logic [19:0] KEEP_EXPECT = 20'hF_FFFF;

  typedef struct packed {
    logic [3:0]         cls;
    logic signed [15:0] score;
  } res_t;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cl_sde_argmax.sv
// cl_sde_argmax
//   Two-stage pipelined argmax over NUM_CLASSES signed scores.
//   Stage 1 registers the winner of each adjacent pair, stage 2 reduces
//   the pair winners to a single (class, score). Ties go to the lower index.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_in     scores_in carries a beat this cycle
//   scores_in    NUM_CLASSES packed signed scores, class i at [16i+15:16i]
//   valid_out    res_out holds a result (2 cycles after valid_in)
//   res_out      winning class index and score
//   inflight     number of beats currently inside the pipe (0..2)
module cl_sde_argmax
  import cl_sde_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
  output logic                           valid_out,
  output res_t                           res_out,
  output logic [1:0]                     inflight
);

  localparam int NUM_PAIRS = (NUM_CLASSES + 1) / 2;

  res_t pair_win [NUM_PAIRS];
  res_t s1_reg   [NUM_PAIRS];
  logic s1_valid_reg;
  res_t best;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
      localparam int LO = 2 * gi;
      localparam int HI = 2 * gi + 1;
      logic signed [SCORE_W-1:0] lo_score;
      assign lo_score = scores_in[LO*SCORE_W +: SCORE_W];
      if (HI < NUM_CLASSES) begin : g_two
        logic signed [SCORE_W-1:0] hi_score;
        assign hi_score = scores_in[HI*SCORE_W +: SCORE_W];
        // >= keeps the lower index when the pair ties
        assign pair_win[gi] = (lo_score >= hi_score) ? {CLS_W'(LO), lo_score}
                                                     : {CLS_W'(HI), hi_score};
      end else begin : g_one
        assign pair_win[gi] = {CLS_W'(LO), lo_score};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      for (int i = 0; i < NUM_PAIRS; i++) s1_reg[i] <= '0;
    end else begin
      s1_valid_reg <= valid_in;
      if (valid_in) begin
        for (int i = 0; i < NUM_PAIRS; i++) s1_reg[i] <= pair_win[i];
      end
    end
  end

  // Pair winners are ordered by index, so a strict > keeps the earlier one on ties.
  always_comb begin
    best = s1_reg[0];
    for (int i = 1; i < NUM_PAIRS; i++) begin
      if ($signed(s1_reg[i].score) > $signed(best.score)) best = s1_reg[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      res_out   <= '0;
    end else begin
      valid_out <= s1_valid_reg;
      if (s1_valid_reg) res_out <= best;
    end
  end

  assign inflight = {1'b0, s1_valid_reg} + {1'b0, valid_out};

endmodule

// File: rtl/cl_sde_class_rx.sv
// cl_sde_class_rx
//   Sink for the SDE classifier result stream. Each accepted 512b beat is
//   reduced to (class, max score) by cl_sde_argmax and pushed into a result
//   FIFO that the host drains through the cfg register port. Keep/last
//   protocol errors and the number of stored results are counted.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ins_valid/ins_ready   beat handshake
//   ins_data              scores in [159:0], remaining bits ignored
//   ins_keep, ins_last    protocol qualifiers, checked and counted only
//   cfg_addr/wr/rd/wdata  register access strobes (1 cycle)
//   cfg_ack, cfg_rdata    response, one cycle after the strobe
//   result_avail          result FIFO is non-empty
module cl_sde_class_rx
  import cl_sde_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ins_valid,
  input  logic [511:0] ins_data,
  input  logic [63:0]  ins_keep,
  input  logic         ins_last,
  output logic         ins_ready,
  input  logic [11:0]  cfg_addr,
  input  logic         cfg_wr,
  input  logic         cfg_rd,
  input  logic [31:0]  cfg_wdata,
  output logic         cfg_ack,
  output logic [31:0]  cfg_rdata,
  output logic         result_avail
);

  logic             enable_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [31:0]      num_results_reg;
  logic [31:0]      keep_err_reg;
  logic [31:0]      last_err_reg;
  res_t             mem [FIFO_DEPTH];

  logic       ar_valid;
  res_t       ar_res;
  logic [1:0] inflight;

  logic beat, push, pop, rd_only, ctrl_wr, clear, empty, full;
  logic [31:0] status_word, result_word;
  logic unused_ok;

  cl_sde_argmax u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (beat),
    .scores_in (ins_data[NUM_CLASSES*SCORE_W-1:0]),
    .valid_out (ar_valid),
    .res_out   (ar_res),
    .inflight  (inflight)
  );

  // Beats already inside the pipe reserve a FIFO slot, so a push never
  // finds the FIFO full.
  assign ins_ready = enable_reg &&
                     (({1'b0, count_reg} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH));
  assign beat      = ins_valid && ins_ready;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == CNT_W'(FIFO_DEPTH));
  assign result_avail = !empty;

  // A simultaneous write and read performs only the write.
  assign rd_only = cfg_rd && !cfg_wr;
  assign push    = ar_valid;
  assign pop     = rd_only && (cfg_addr == REG_RESULT) && !empty;
  assign ctrl_wr = cfg_wr && (cfg_addr == REG_CTRL);
  assign clear   = ctrl_wr && cfg_wdata[1];

  assign status_word = {22'd0, full, empty, 3'd0, count_reg};
  assign result_word = {1'b1, 11'd0, mem[rd_ptr_reg].score, mem[rd_ptr_reg].cls};

  assign unused_ok = ^{ins_data[511:NUM_CLASSES*SCORE_W], ins_keep[63:20], cfg_wdata[31:2]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= ar_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_reg      <= 1'b0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      num_results_reg <= '0;
      keep_err_reg    <= '0;
      last_err_reg    <= '0;
      cfg_ack         <= 1'b0;
      cfg_rdata       <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (ctrl_wr) enable_reg <= cfg_wdata[0];

      if (clear) begin
        num_results_reg <= '0;
        keep_err_reg    <= '0;
        last_err_reg    <= '0;
      end else begin
        if (push) num_results_reg <= sat_inc(num_results_reg);
        if (beat && (ins_keep[19:0] != KEEP_EXPECT)) keep_err_reg <= sat_inc(keep_err_reg);
        if (beat && !ins_last) last_err_reg <= sat_inc(last_err_reg);
      end

      cfg_ack   <= cfg_wr || cfg_rd;
      cfg_rdata <= '0;
      if (rd_only) begin
        case (cfg_addr)
          REG_CTRL:        cfg_rdata <= {31'd0, enable_reg};
          REG_STATUS:      cfg_rdata <= status_word;
          REG_RESULT:      cfg_rdata <= empty ? 32'd0 : result_word;
          REG_NUM_RESULTS: cfg_rdata <= num_results_reg;
          REG_KEEP_ERR:    cfg_rdata <= keep_err_reg;
          REG_LAST_ERR:    cfg_rdata <= last_err_reg;
          default:         cfg_rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cl_sde_class_rx.sv
module tb_cl_sde_class_rx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ins_valid = 1'b0;
  logic [511:0] ins_data = '0;
  logic [63:0]  ins_keep = '0;
  logic         ins_last = 1'b0;
  logic         ins_ready;
  logic [11:0]  cfg_addr = '0;
  logic         cfg_wr = 1'b0;
  logic         cfg_rd = 1'b0;
  logic [31:0]  cfg_wdata = '0;
  logic         cfg_ack;
  logic [31:0]  cfg_rdata;
  logic         result_avail;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] KEEP_OK = 64'h0000_0000_000F_FFFF;

  logic [15:0] sc [10];

  cl_sde_class_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ins_valid    (ins_valid),
    .ins_data     (ins_data),
    .ins_keep     (ins_keep),
    .ins_last     (ins_last),
    .ins_ready    (ins_ready),
    .cfg_addr     (cfg_addr),
    .cfg_wr       (cfg_wr),
    .cfg_rd       (cfg_rd),
    .cfg_wdata    (cfg_wdata),
    .cfg_ack      (cfg_ack),
    .cfg_rdata    (cfg_rdata),
    .result_avail (result_avail)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pack_scores();
    logic [511:0] d = '0;
    for (int i = 0; i < 10; i++) d[16*i +: 16] = sc[i];
    d[511:160] = {11{32'hDEAD_BEEF}};
    return d;
  endfunction

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 10; i++) sc[i] = v;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // All tasks start and end on a falling edge.
  task automatic cfg_read(input logic [11:0] addr, output logic [31:0] data, output logic ack);
    cfg_addr = addr;
    cfg_rd   = 1'b1;
    @(negedge clk);
    cfg_rd = 1'b0;
    data   = cfg_rdata;
    ack    = cfg_ack;
  endtask

  task automatic cfg_write(input logic [11:0] addr, input logic [31:0] data);
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] keep, input logic last);
    int waited = 0;
    ins_data  = pack_scores();
    ins_keep  = keep;
    ins_last  = last;
    ins_valid = 1'b1;
    while (!ins_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (ins_ready !== 1'b1) begin
      bad++;
      $display("FAIL beat_accept ready=%0b required=1", ins_ready);
    end else begin
      @(negedge clk);
    end
    ins_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (ins_ready !== 1'b0)    begin bad++; $display("FAIL rst_ready got=%0b exp=0", ins_ready); end
    total++; if (cfg_ack !== 1'b0)      begin bad++; $display("FAIL rst_ack got=%0b exp=0", cfg_ack); end
    total++; if (cfg_rdata !== 32'd0)   begin bad++; $display("FAIL rst_rdata got=%h exp=0", cfg_rdata); end
    total++; if (result_avail !== 1'b0) begin bad++; $display("FAIL rst_avail got=%0b exp=0", result_avail); end
    wait_cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL rst_disabled_ready got=%0b exp=0", ins_ready); end
    $display("test_reset done");
  endtask

  task automatic test_argmax_basic();
    logic [31:0] d; logic a;
    cfg_write(12'h000, 32'h1);
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL enable_ready got=%0b exp=1", ins_ready); end
    set_all(16'h0010); sc[7] = 16'h0100;
    send_beat(KEEP_OK, 1'b1);
    wait_cycles(3);
    total++; if (result_avail !== 1'b1) begin bad++; $display("FAIL basic_avail got=%0b exp=1", result_avail); end
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8000_1007) begin bad++; $display("FAIL basic_result got=%h exp=80001007", d); end
    total++; if (a !== 1'b1) begin bad++; $display("FAIL basic_ack got=%0b exp=1", a); end
    cfg_read(12'h00C, d, a);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL basic_num_results got=%h exp=1", d); end
    $display("test_argmax_basic result read done");
  endtask

  task automatic test_argmax_patterns();
    logic [31:0] d; logic a;
    // tie between classes 2 and 6
    set_all(16'hFFFB); sc[2] = 16'h7FFF; sc[6] = 16'h7FFF;
    send_beat(KEEP_OK, 1'b1); wait_cycles(3);
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8007_FFF2) begin bad++; $display("FAIL tie_result got=%h exp=8007fff2", d); end
    // all negative, largest is -1 at class 0
    for (int i = 0; i < 10; i++) sc[i] = 16'(-(i + 1));
    send_beat(KEEP_OK, 1'b1); wait_cycles(3);
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h800F_FFF0) begin bad++; $display("FAIL neg_result got=%h exp=800ffff0", d); end
    // last class wins; negative values elsewhere must not beat +1
    set_all(16'h8000); sc[9] = 16'h0001;
    send_beat(KEEP_OK, 1'b1); wait_cycles(3);
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8000_0019) begin bad++; $display("FAIL top_index_result got=%h exp=80000019", d); end
    // all equal -> class 0
    set_all(16'h1234);
    send_beat(KEEP_OK, 1'b1); wait_cycles(3);
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8001_2340) begin bad++; $display("FAIL all_equal_result got=%h exp=80012340", d); end
    $display("test_argmax_patterns done");
  endtask

  task automatic test_backpressure();
    logic [31:0] d, e; logic a;
    int n;
    for (int k = 0; k < 16; k++) begin
      set_all(16'h0000); sc[k % 10] = 16'(k + 1);
      send_beat(KEEP_OK, 1'b1);
    end
    set_all(16'h0000); sc[6] = 16'd17;
    ins_data = pack_scores(); ins_keep = KEEP_OK; ins_last = 1'b1; ins_valid = 1'b1;
    wait_cycles(3);
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", ins_ready); end
    cfg_read(12'h004, d, a);
    total++; if (d !== 32'h0000_0210) begin bad++; $display("FAIL full_status got=%h exp=210", d); end
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8000_0010) begin bad++; $display("FAIL full_pop_result got=%h exp=80000010", d); end
    n = 0;
    while (!ins_ready && n < 3) begin @(negedge clk); n++; end
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL refill_ready got=%0b exp=1", ins_ready); end
    @(negedge clk);
    ins_valid = 1'b0;
    wait_cycles(3);
    for (int k = 1; k < 17; k++) begin
      e = {1'b1, 11'd0, 16'(k + 1), 4'(k % 10)};
      cfg_read(12'h008, d, a);
      total++; if (d !== e) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", k, d, e); end
    end
    cfg_read(12'h004, d, a);
    total++; if (d !== 32'h0000_0100) begin bad++; $display("FAIL drained_status got=%h exp=100", d); end
    $display("test_backpressure done");
  endtask

  task automatic test_errors_clear();
    logic [31:0] d; logic a;
    set_all(16'h0000); sc[4] = 16'h0123;
    send_beat(64'h0000_0000_0000_FFFF, 1'b0); wait_cycles(3);
    cfg_read(12'h010, d, a);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL keep_err got=%h exp=1", d); end
    cfg_read(12'h014, d, a);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL last_err got=%h exp=1", d); end
    cfg_read(12'h004, d, a);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL err_status got=%h exp=1", d); end
    cfg_write(12'h000, 32'h3);
    cfg_read(12'h010, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_keep_err got=%h exp=0", d); end
    cfg_read(12'h014, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_last_err got=%h exp=0", d); end
    cfg_read(12'h00C, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_num_results got=%h exp=0", d); end
    cfg_read(12'h000, d, a);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL clr_ctrl got=%h exp=1", d); end
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8000_1234) begin bad++; $display("FAIL err_result got=%h exp=80001234", d); end
    set_all(16'h0000);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1); wait_cycles(3);
    cfg_read(12'h010, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL upper_keep_err got=%h exp=0", d); end
    cfg_read(12'h00C, d, a);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL post_clr_num got=%h exp=1", d); end
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL zero_result got=%h exp=80000000", d); end
    $display("test_errors_clear done");
  endtask

  task automatic test_empty_unmapped();
    logic [31:0] d; logic a;
    cfg_read(12'h008, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL empty_result got=%h exp=0", d); end
    total++; if (a !== 1'b1) begin bad++; $display("FAIL empty_ack got=%0b exp=1", a); end
    cfg_read(12'h004, d, a);
    total++; if (d !== 32'h0000_0100) begin bad++; $display("FAIL empty_status got=%h exp=100", d); end
    cfg_read(12'h040, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
    cfg_write(12'h040, 32'h0);
    cfg_read(12'h000, d, a);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL unmapped_write_ctrl got=%h exp=1", d); end
    cfg_addr = 12'h000; cfg_wdata = 32'h1; cfg_wr = 1'b1; cfg_rd = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    total++; if (cfg_rdata !== 32'd0) begin bad++; $display("FAIL wr_rd_rdata got=%h exp=0", cfg_rdata); end
    total++; if (cfg_ack !== 1'b1) begin bad++; $display("FAIL wr_rd_ack got=%0b exp=1", cfg_ack); end
    $display("test_empty_unmapped done");
  endtask

  task automatic test_midreset();
    logic [31:0] d; logic a;
    set_all(16'h0000); sc[3] = 16'h0055;
    ins_data = pack_scores(); ins_keep = KEEP_OK; ins_last = 1'b1; ins_valid = 1'b1;
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL midrst_pre_ready got=%0b exp=1", ins_ready); end
    wait_cycles(2);
    ins_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%0b exp=0", ins_ready); end
    @(negedge clk);
    wait_cycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_write(12'h000, 32'h1);
    wait_cycles(4);
    cfg_read(12'h004, d, a);
    total++; if (d !== 32'h0000_0100) begin bad++; $display("FAIL midrst_status got=%h exp=100", d); end
    cfg_read(12'h00C, d, a);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL midrst_num_results got=%h exp=0", d); end
    total++; if (result_avail !== 1'b0) begin bad++; $display("FAIL midrst_avail got=%0b exp=0", result_avail); end
    $display("test_midreset done");
  endtask

  initial begin
    set_all(16'h0000);
    test_reset();
    test_argmax_basic();
    test_argmax_patterns();
    test_backpressure();
    test_errors_clear();
    test_empty_unmapped();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
